// File: rtl/nextbtn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-interval debounce FSM, press pulse.
// Optional hold-to-repeat pulses are built when AUTO_REPEAT_EN is defined.
module nextbtn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 20_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic btn_pulse,
   output logic btn_db
);

   localparam int CTR_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("nextbtn_debounce: cycle-count parameters must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   logic             s1_q;
   logic             s2_q;
   state_t           state_q;
   logic [CTR_W-1:0] ctr_q;
   logic             pulse_q;
   logic             db_q;

`ifdef AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
   localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] rep_q;
   logic             rep_first_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= IDLE;
         ctr_q   <= '0;
         pulse_q <= 1'b0;
         db_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rep_q       <= '0;
         rep_first_q <= 1'b1;
`endif
      end else begin
         s1_q    <= btn_in;
         s2_q    <= s1_q;
         pulse_q <= 1'b0;

         case (state_q)
            IDLE: begin
               ctr_q <= '0;
               if (s2_q) state_q <= PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!s2_q) begin
                  state_q <= IDLE;
                  ctr_q   <= '0;
               end else if (ctr_q == CTR_LAST) begin
                  state_q <= PRESSED;
                  ctr_q   <= '0;
                  pulse_q <= 1'b1;
                  db_q    <= 1'b1;
               end else begin
                  ctr_q <= ctr_q + 1'b1;
               end
            end
            PRESSED: begin
               ctr_q <= '0;
               if (!s2_q) state_q <= RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
               // A short low excursion returns to PRESSED silently; only a full interval releases.
               if (s2_q) begin
                  state_q <= PRESSED;
                  ctr_q   <= '0;
               end else if (ctr_q == CTR_LAST) begin
                  state_q <= IDLE;
                  ctr_q   <= '0;
                  db_q    <= 1'b0;
               end else begin
                  ctr_q <= ctr_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ctr_q   <= '0;
               db_q    <= 1'b0;
            end
         endcase

`ifdef AUTO_REPEAT_EN
         // Press pulse happens only on PRESS_WAIT exit, so it never collides with a repeat pulse.
         case (state_q)
            PRESSED: begin
               if (rep_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                  pulse_q     <= 1'b1;
                  rep_q       <= '0;
                  rep_first_q <= 1'b0;
               end else begin
                  rep_q <= rep_q + 1'b1;
               end
            end
            RELEASE_WAIT: begin
               rep_q       <= rep_q;
               rep_first_q <= rep_first_q;
            end
            default: begin
               rep_q       <= '0;
               rep_first_q <= 1'b1;
            end
         endcase
`endif
      end
   end

   assign btn_pulse = pulse_q;
   assign btn_db    = db_q;

endmodule
